seq_game_ctrl: RTL and testbench



---
 rtl/seq_game_ctrl.sv | 89 ++++++++
 tb/tb_seq_game_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_game_ctrl.sv
// seq_game_ctrl: memory-game round controller; replays the first level ROM steps on the LEDs,
// then checks the player's one-hot presses against the same ROM, growing the level up to 16.
module seq_game_ctrl #(
  parameter int SHOW_TICKS    = 2,
  parameter int GAP_TICKS     = 1,
  parameter int TIMEOUT_TICKS = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       tick,
  input  logic [3:0] btn,
  input  logic [3:0] rom_data,
  output logic [3:0] address,
  output logic [3:0] leds,
  output logic [4:0] level,
  output logic       win,
  output logic       lose
);
  typedef enum logic [2:0] {IDLE, SHOW_ON, SHOW_OFF, INPUT, WIN, LOSE} state_t;
  state_t state, state_n;
  logic [3:0] idx, idx_n;
  logic [4:0] level_n;
  logic [7:0] tcnt, tcnt_n;
  logic pre, pre_n;
  logic last, show_done, gap_done, timeout;
  assign last      = {1'b0, idx} == level - 5'd1;
  assign show_done = tick && tcnt == 8'(SHOW_TICKS - 1);
  assign gap_done  = tick && tcnt == 8'(GAP_TICKS - 1);
  assign timeout   = tick && tcnt == 8'(TIMEOUT_TICKS - 1);
  assign address   = idx;
  assign leds      = state == SHOW_ON ? rom_data : 4'd0;
  assign win       = state == WIN;
  assign lose      = state == LOSE;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      level <= '0;
      tcnt  <= '0;
      pre   <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      level <= level_n;
      tcnt  <= tcnt_n;
      pre   <= pre_n;
    end
  // pre marks the dark gap that precedes each replay, before step 0 is lit
  always_comb begin
    state_n = state;
    idx_n   = idx;
    level_n = level;
    pre_n   = pre;
    tcnt_n  = tick ? tcnt + 8'd1 : tcnt;
    case (state)
      IDLE, WIN, LOSE:
        if (start) begin
          state_n = SHOW_OFF;
          level_n = 5'd1;
          idx_n   = '0;
          pre_n   = 1'b1;
        end
      SHOW_ON: if (show_done) state_n = SHOW_OFF;
      SHOW_OFF:
        if (gap_done) begin
          pre_n   = 1'b0;
          state_n = pre || !last ? SHOW_ON : INPUT;
          idx_n   = pre || last ? 4'd0 : idx + 4'd1;
        end
      INPUT:
        if (btn != 4'd0) begin
          if (btn != rom_data) state_n = LOSE;
          else if (!last) begin
            idx_n  = idx + 4'd1;
            tcnt_n = '0;
          end else if (level == 5'd16) state_n = WIN;
          else begin
            state_n = SHOW_OFF;
            level_n = level + 5'd1;
            idx_n   = '0;
            pre_n   = 1'b1;
          end
        end else if (timeout) state_n = LOSE;
      default: state_n = IDLE;
    endcase
    if (state_n != state) tcnt_n = '0;
  end
endmodule

// File: tb/tb_seq_game_ctrl.sv
// tb_seq_game_ctrl: plays games against a ROM model, predicting the per-tick LED replay
// timeline and the level/idx/win/lose outcome of each press from the game rules.
module tb_seq_game_ctrl;
  localparam int S = 2, G = 1, TO = 8;
  logic clock = 0, reset = 1, start = 0, tick = 0;
  logic [3:0] btn = 0, rom_data, address, leds;
  logic [4:0] level;
  logic win, lose;
  logic [3:0] rom [0:15];
  logic [3:0] obs [0:63];
  int checks = 0, failures = 0, gen = 0;

  seq_game_ctrl #(.SHOW_TICKS(S), .GAP_TICKS(G), .TIMEOUT_TICKS(TO)) dut (
    .clock(clock), .reset(reset), .start(start), .tick(tick), .btn(btn), .rom_data(rom_data),
    .address(address), .leds(leds), .level(level), .win(win), .lose(lose));

  assign rom_data = rom[address];
  always #5 clock = ~clock;
  initial forever begin
    @(negedge clock);
    tick = gen == 3;
    gen = (gen + 1) % 4;
  end

  task automatic cyc();
    @(negedge clock);
    #1;
  endtask

  function automatic logic [3:0] exp_led(input int i);
    int j;
    if (i < G) return 4'd0;
    j = i - G;
    return (j % (S + G)) < S ? rom[j / (S + G)] : 4'd0;
  endfunction

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      while (tick == 0) cyc();
      obs[i] = leds;
      cyc();
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      while (tick == 0) cyc();
      cyc();
    end
  endtask

  task automatic press(input logic [3:0] v, input bit on_tick);
    while (tick !== on_tick) cyc();
    btn = v;
    cyc();
    btn = 0;
  endtask

  task automatic do_start();
    start = 1;
    cyc();
    start = 0;
  endtask

  task automatic replay(input int lvl);
    int t;
    t = G + lvl * (S + G);
    capture(t);
    for (int i = 0; i < t; i++) begin
      checks++;
      if (obs[i] !== exp_led(i)) begin
        failures++;
        $display("FAIL replay lvl=%0d tick=%0d leds=%b expected=%b", lvl, i, obs[i], exp_led(i));
      end
    end
    checks++;
    if (level !== 5'(lvl) || address !== 0 || leds !== 0 || win !== 0 || lose !== 0) begin
      failures++;
      $display("FAIL input_entry lvl=%0d got level=%0d addr=%0d leds=%b win=%b lose=%b", lvl, level, address, leds, win, lose);
    end
  endtask

  task automatic play_round(input int lvl);
    replay(lvl);
    for (int s = 0; s < lvl; s++) begin
      repeat ($urandom_range(0, 12)) cyc();
      press(rom[s], 0);
      checks++;
      if (s < lvl - 1 && (address !== 4'(s + 1) || lose !== 0)) begin
        failures++;
        $display("FAIL step lvl=%0d s=%0d addr=%0d lose=%b expected addr=%0d", lvl, s, address, lose, s + 1);
      end else if (s == lvl - 1 && lvl < 16 && (level !== 5'(lvl + 1) || address !== 0 || lose !== 0)) begin
        failures++;
        $display("FAIL level_up lvl=%0d level=%0d addr=%0d lose=%b expected level=%0d", lvl, level, address, lose, lvl + 1);
      end else if (s == lvl - 1 && lvl == 16 && (win !== 1 || level !== 5'd16)) begin
        failures++;
        $display("FAIL win win=%b level=%0d expected win=1 level=16", win, level);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1;
    #2;
    checks++;
    if ({address, leds, level, win, lose} !== 15'd0) begin
      failures++;
      $display("FAIL reset addr=%0d leds=%b level=%0d win=%b lose=%b expected all 0", address, leds, level, win, lose);
    end
    cyc();
    reset = 0;
    cyc();
  endtask

  task automatic test_wrong_press();
    do_start();
    play_round(1);
    replay(2);
    press(rom[0], 0);
    press(4'b0100, 0);
    checks++;
    if (lose !== 1 || address !== 1 || level !== 2) begin
      failures++;
      $display("FAIL wrong_press lose=%b addr=%0d level=%0d expected lose=1 addr=1 level=2", lose, address, level);
    end
    do_start();
    checks++;
    if (lose !== 0 || level !== 1 || address !== 0) begin
      failures++;
      $display("FAIL restart_after_lose lose=%b level=%0d addr=%0d expected 0/1/0", lose, level, address);
    end
  endtask

  task automatic test_timeout();
    replay(1);
    wait_ticks(TO - 1);
    checks++;
    if (lose !== 0) begin
      failures++;
      $display("FAIL timeout_early lose=%b expected 0 after %0d ticks", lose, TO - 1);
    end
    wait_ticks(1);
    checks++;
    if (lose !== 1 || level !== 1) begin
      failures++;
      $display("FAIL timeout lose=%b level=%0d expected lose=1 level=1", lose, level);
    end
  endtask

  task automatic test_press_on_tick();
    do_start();
    play_round(1);
    replay(2);
    wait_ticks(TO - 2);
    press(rom[0], 1);
    checks++;
    if (address !== 1 || lose !== 0) begin
      failures++;
      $display("FAIL press_on_tick addr=%0d lose=%b expected addr=1 lose=0", address, lose);
    end
    wait_ticks(TO - 1);
    checks++;
    if (lose !== 0) begin
      failures++;
      $display("FAIL tcnt_cleared lose=%b expected 0", lose);
    end
    wait_ticks(1);
    checks++;
    if (lose !== 1 || address !== 1) begin
      failures++;
      $display("FAIL timeout_after_press lose=%b addr=%0d expected lose=1 addr=1", lose, address);
    end
  endtask

  task automatic test_multi_hot();
    do_start();
    replay(1);
    press(4'b1001, 0);
    checks++;
    if (lose !== 1 || address !== 0 || level !== 1) begin
      failures++;
      $display("FAIL multi_hot lose=%b addr=%0d level=%0d expected 1/0/1", lose, address, level);
    end
  endtask

  task automatic test_reset_mid_show();
    int n;
    do_start();
    n = 0;
    while (leds == 0 && n < 100) begin
      cyc();
      n++;
    end
    checks++;
    if (leds === 0) begin
      failures++;
      $display("FAIL show_on_timeout leds=%b expected nonzero within 100 cycles", leds);
    end
    reset = 1;
    #1;
    checks++;
    if ({address, leds, level, win, lose} !== 15'd0) begin
      failures++;
      $display("FAIL reset_mid_show addr=%0d leds=%b level=%0d win=%b lose=%b expected all 0", address, leds, level, win, lose);
    end
    cyc();
    reset = 0;
    cyc();
  endtask

  task automatic test_win();
    do_start();
    for (int l = 1; l <= 16; l++) play_round(l);
    repeat (3) press(4'(1 << $urandom_range(0, 3)), 0);
    checks++;
    if (win !== 1 || level !== 16 || address !== 15) begin
      failures++;
      $display("FAIL win_hold win=%b level=%0d addr=%0d expected 1/16/15", win, level, address);
    end
    do_start();
    checks++;
    if (win !== 0 || level !== 1 || address !== 0) begin
      failures++;
      $display("FAIL restart_after_win win=%b level=%0d addr=%0d expected 0/1/0", win, level, address);
    end
    replay(1);
  endtask

  initial begin
    rom[0] = 4'b0001;
    rom[1] = 4'b1000;
    rom[2] = 4'b0100;
    rom[3] = 4'b1000;
    for (int i = 4; i < 16; i++) rom[i] = 4'(1 << $urandom_range(0, 3));
    test_reset();
    test_wrong_press();
    test_timeout();
    test_press_on_tick();
    test_multi_hot();
    test_reset_mid_show();
    test_win();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
